fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Controller that sequences the shared dual-address vector RAM (`ram_vector`) as a synchronous FIFO.
- Owns the write and read pointers and the occupancy count, and produces the `wr_en`/`rd_en` strobes for the RAM.
- Produces full/empty/almost flags, sticky overflow/underflow errors, and a `data_valid` strobe aligned to the RAM's 1-cycle registered read.
- Sits between requesters (`push`/`pop`) and `ram_vector`; the top-level FIFO wraps both.

Parameters:
- DEPTH, VECTOR_SIZE (fifo_pkg): number of RAM entries; any value >= 2; wrap is explicit, so powers of two are not required.
- AF_TH, DEPTH-2: `almost_full` asserts when `usedw >= AF_TH`.
- AE_TH, 2: `almost_empty` asserts when `usedw <= AE_TH`.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write request; data is presented to the RAM `data_in` by the top level in the same cycle.
- pop  in  1  read request.
- clr_err  in  1  synchronous clear of the sticky error flags.
- wr_en  out  1  RAM write strobe (combinational).
- rd_en  out  1  RAM read strobe (combinational).
- count_push  out  address_t  RAM write address = current write pointer (registered).
- count_pop  out  address_t  RAM read address = current read pointer (registered).
- usedw  out  usedw_t ($clog2(DEPTH)+1 bits)  occupancy, 0..DEPTH.
- full  out  1  `usedw == DEPTH`.
- empty  out  1  `usedw == 0`.
- almost_full  out  1  see AF_TH.
- almost_empty  out  1  see AE_TH.
- data_valid  out  1  RAM `data_out` holds a popped word this cycle.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wptr=0, rptr=0, usedw=0, state=S_EMPTY.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - data_valid=0, overflow=0, underflow=0.
  - While rst=1, `wr_en` and `rd_en` are forced to 0.
  - Reset mid-operation discards contents; RAM data is not cleared, only the pointers.
- Acceptance (combinational):
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok).
  - wr_en = push_ok; rd_en = pop_ok.
- Pointer update on the clock edge:
  - wptr advances on push_ok; rptr advances on pop_ok.
  - Each pointer wraps from DEPTH-1 to 0.
- Occupancy update:
  - push_ok only: usedw+1.
  - pop_ok only: usedw-1.
  - Both, or neither: unchanged.
- Full with simultaneous push+pop:
  - Both are accepted and `wptr == rptr`.
  - The RAM read returns the old word (read-before-write); the new word is written to the same address.
  - full stays 1.
- Empty with simultaneous push+pop: pop is rejected (no bypass), underflow is set, push is accepted, and usedw becomes 1.
- Latency:
  - data_valid is the registered rd_en and rises 1 cycle after the accepted pop, aligned with RAM `data_out`.
  - Flags and usedw are registered and reflect accepted operations in the cycle after the edge.
- State machine (drives the flags):
  - States: S_EMPTY, S_MID, S_FULL.
  - S_EMPTY -> S_MID on push_ok.
  - S_MID -> S_FULL when the net push brings usedw to DEPTH.
  - S_MID -> S_EMPTY when the net pop brings usedw to 0.
  - S_FULL -> S_MID on pop-only.
  - Push+pop leaves the state unchanged.
- Error flags:
  - overflow is set when push & !push_ok; underflow is set when pop & !pop_ok.
  - Both stay set until rst or clr_err.
  - If clr_err coincides with a new error, the set wins.

Decomposition:
- fifo_pkg holds:
  - data_t, address_t, VECTOR_SIZE;
  - usedw_t;
  - the fifo_state_t enum {S_EMPTY, S_MID, S_FULL}.
- One natural sub-module, `fifo_ptr`: a wrapping address counter with inc and sync clear, instantiated twice (write and read).
- The top-level `fifo` instantiates fifo_ctrl + ram_vector; that wrapper is not part of this block.

Test Plan (all with DEPTH=8):
- Reset check: rst 2 cycles -> empty=1, full=0, usedw=0, count_push=count_pop=0, all strobes and errors 0.
- Fill: 8 pushes of 0x11..0x88 -> wr_en high each cycle, count_push 0..7; full=1 and usedw=8 after the 8th; a 9th push gives wr_en=0, overflow=1, count_push=0.
- Drain: 8 pops -> rd_en high, count_pop 0..7, data_valid 1 cycle later each, RAM out 0x11..0x88; empty=1 at the end; a 9th pop gives rd_en=0, underflow=1.
- Simultaneous ops:
  - At full, push+pop -> both strobes high, usedw stays 8, the popped word is the old one.
  - At empty, push+pop -> only wr_en high, usedw=1, underflow=1.
- Wrap-around: fill 8, pop 3, push 3 -> count_push shows 0,1,2 (wrapped), usedw=8; then pop 8 -> count_pop 3..7,0,1,2, data in FIFO order.
- Reset mid-stream and clr_err:
  - With usedw=5, assert rst -> next cycle pointers=0, usedw=0, data_valid=0.
  - clr_err after an overflow -> overflow=0 the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing, types and state encoding for the FIFO controller.
//   DEPTH       number of RAM entries (>= 2, any value; wrap is explicit)
//   VECTOR_SIZE RAM word width
//   data_t / address_t / usedw_t and the fifo_state_t controller states.
package fifo_pkg;

  localparam int DEPTH       = 8;
  localparam int VECTOR_SIZE = 8;
  localparam int ADDR_W      = $clog2(DEPTH);
  // One extra bit so the occupancy can represent DEPTH itself.
  localparam int USEDW_W     = $clog2(DEPTH) + 1;

  typedef logic [VECTOR_SIZE-1:0] data_t;
  typedef logic [ADDR_W-1:0]      address_t;
  typedef logic [USEDW_W-1:0]     usedw_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MID   = 2'd1,
    S_FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// fifo_ptr: wrapping RAM address counter (0..DEPTH-1) with synchronous clear.
//   clk_i  clock, rising edge
//   clr_i  synchronous clear to 0 (dominates inc_i)
//   inc_i  advance by one, wrapping DEPTH-1 -> 0
//   ptr_o  current (registered) address
module fifo_ptr
  import fifo_pkg::*;
(
  input  logic     clk_i,
  input  logic     clr_i,
  input  logic     inc_i,
  output address_t ptr_o
);

  address_t ptr_q, ptr_d;

  // Explicit compare-and-wrap so non-power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i)
      ptr_d = (ptr_q == address_t'(DEPTH - 1)) ? '0 : ptr_q + address_t'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequences a dual-address vector RAM as a synchronous FIFO.
//   clk_i / rst_i        clock and synchronous active-high reset
//   push_i / pop_i       write / read requests
//   clr_err_i            clears the sticky overflow/underflow flags
//   wr_en_o / rd_en_o    RAM strobes (combinational from accepted requests)
//   count_push_o/_pop_o  RAM write / read addresses (registered pointers)
//   usedw_o              occupancy 0..DEPTH
//   full/empty/almost_*  status flags
//   data_valid_o         RAM data_out carries a popped word this cycle
//   overflow/underflow_o sticky rejected-push / rejected-pop errors
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  logic     clr_err_i,
  output logic     wr_en_o,
  output logic     rd_en_o,
  output address_t count_push_o,
  output address_t count_pop_o,
  output usedw_t   usedw_o,
  output logic     full_o,
  output logic     empty_o,
  output logic     almost_full_o,
  output logic     almost_empty_o,
  output logic     data_valid_o,
  output logic     overflow_o,
  output logic     underflow_o
);

  fifo_state_t state_q, state_d;
  usedw_t      usedw_q, usedw_d;
  logic        dv_q;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        push_ok, pop_ok;

  assign empty_o = (state_q == S_EMPTY);
  assign full_o  = (state_q == S_FULL);

  // No empty bypass: a pop needs stored data. At full, a push is still
  // taken alongside a pop (RAM reads before it writes the same address).
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign wr_en_o = push_ok & ~rst_i;
  assign rd_en_o = pop_ok  & ~rst_i;

  fifo_ptr u_wptr (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (push_ok),
    .ptr_o (count_push_o)
  );

  fifo_ptr u_rptr (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (pop_ok),
    .ptr_o (count_pop_o)
  );

  always_comb begin
    usedw_d = usedw_q;
    case ({push_ok, pop_ok})
      2'b10:   usedw_d = usedw_q + usedw_t'(1);
      2'b01:   usedw_d = usedw_q - usedw_t'(1);
      default: usedw_d = usedw_q;
    endcase
  end

  // Only a net push or net pop can move the state; push+pop holds it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push_ok) state_d = S_MID;
      S_MID: begin
        if (push_ok && !pop_ok && usedw_q == usedw_t'(DEPTH - 1))
          state_d = S_FULL;
        else if (pop_ok && !push_ok && usedw_q == usedw_t'(1))
          state_d = S_EMPTY;
      end
      S_FULL:  if (pop_ok && !push_ok) state_d = S_MID;
      default: state_d = S_EMPTY;
    endcase
  end

  // A fresh error takes priority over a coincident clear.
  assign ovf_d = (push_i & ~push_ok) | (ovf_q & ~clr_err_i);
  assign udf_d = (pop_i  & ~pop_ok)  | (udf_q & ~clr_err_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      usedw_q <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      usedw_q <= usedw_d;
      dv_q    <= rd_en_o;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign usedw_o        = usedw_q;
  assign almost_full_o  = (usedw_q >= usedw_t'(AF_TH));
  assign almost_empty_o = (usedw_q <= usedw_t'(AE_TH));
  assign data_valid_o   = dv_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic     clk = 1'b0;
  logic     rst, push, pop, clr_err;
  logic     wr_en, rd_en, full, empty, af, ae, dv, ovf, udf;
  address_t cpush, cpop;
  usedw_t   usedw;
  data_t    din, ram_q;
  data_t    mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  data_t mq[$];   // reference FIFO contents
  data_t rdq[$];  // words expected on data_valid, in order

  typedef struct {
    logic       push, pop, clr;
    data_t      din;
    logic       wr, rd;
    logic [2:0] cp, cr;
    logic [3:0] uw;
    logic       fl, em, dv, ov, ud;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .push_i         (push),
    .pop_i          (pop),
    .clr_err_i      (clr_err),
    .wr_en_o        (wr_en),
    .rd_en_o        (rd_en),
    .count_push_o   (cpush),
    .count_pop_o    (cpop),
    .usedw_o        (usedw),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (af),
    .almost_empty_o (ae),
    .data_valid_o   (dv),
    .overflow_o     (ovf),
    .underflow_o    (udf)
  );

  // Environment RAM: registered read, read-before-write on the same address.
  always @(posedge clk) begin
    if (wr_en) mem[cpush] <= din;
    if (rd_en) ram_q <= mem[cpop];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every data_valid must deliver the next expected word.
  always @(negedge clk) begin
    if (dv === 1'b1) begin
      if (rdq.size() == 0) chk("dv_spurious", 32'(dv), 32'd0);
      else                 chk("rd_data", 32'(ram_q), 32'(rdq.pop_front()));
    end
  end

  function automatic vec_t mk(logic pu, logic po, logic cl, logic [7:0] d,
                              logic wr, logic rd, int cp, int cr, int uw,
                              logic fl, logic em, logic dvv, logic ov, logic ud);
    vec_t v;
    v.push = pu; v.pop = po; v.clr = cl; v.din = d;
    v.wr = wr; v.rd = rd; v.cp = 3'(cp); v.cr = 3'(cr); v.uw = 4'(uw);
    v.fl = fl; v.em = em; v.dv = dvv; v.ov = ov; v.ud = ud;
    return v;
  endfunction

  // Drive one cycle, check pre-edge outputs, then update the reference FIFO.
  task automatic apply(input vec_t v, input string tag);
    bit pok, wok;
    push = v.push; pop = v.pop; clr_err = v.clr; din = v.din;
    @(negedge clk);
    chk({tag, ".wr_en"},  32'(wr_en), 32'(v.wr));
    chk({tag, ".rd_en"},  32'(rd_en), 32'(v.rd));
    chk({tag, ".cpush"},  32'(cpush), 32'(v.cp));
    chk({tag, ".cpop"},   32'(cpop),  32'(v.cr));
    chk({tag, ".usedw"},  32'(usedw), 32'(v.uw));
    chk({tag, ".full"},   32'(full),  32'(v.fl));
    chk({tag, ".empty"},  32'(empty), 32'(v.em));
    chk({tag, ".afull"},  32'(af),    32'(v.uw >= 4'd6));
    chk({tag, ".aempty"}, 32'(ae),    32'(v.uw <= 4'd2));
    chk({tag, ".dvalid"}, 32'(dv),    32'(v.dv));
    chk({tag, ".ovf"},    32'(ovf),   32'(v.ov));
    chk({tag, ".udf"},    32'(udf),   32'(v.ud));
    pok = v.pop && (mq.size() != 0);
    wok = v.push && ((mq.size() != DEPTH) || pok);
    if (pok) rdq.push_back(mq.pop_front());
    if (wok) mq.push_back(v.din);
    @(posedge clk); #1;
  endtask

  // Two reset cycles with requests active: strobes must stay low.
  task automatic do_reset();
    rst = 1'b1; push = 1'b1; pop = 1'b1; clr_err = 1'b0; din = 8'hEE;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst.wr_en", 32'(wr_en), 32'd0);
      chk("rst.rd_en", 32'(rd_en), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    mq.delete();
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;

    // Fill, overflow, drain, underflow, error clear, empty push+pop,
    // clear coinciding with a new underflow.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1,0,0, 8'(17*(i+1)), 1,0, i,0, i, 0,(i==0), 0,0,0));
    tbl.push_back(mk(1,0,0, 8'h99, 0,0, 0,0, 8, 1,0, 0,0,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,1,0, 8'h00, 0,1, 0,i, 8-i, (i==0),0, (i>0),1,0));
    tbl.push_back(mk(0,1,0, 8'h00, 0,0, 0,0, 0, 0,1, 1,1,0));
    tbl.push_back(mk(0,0,1, 8'h00, 0,0, 0,0, 0, 0,1, 0,1,1));
    tbl.push_back(mk(0,0,0, 8'h00, 0,0, 0,0, 0, 0,1, 0,0,0));
    tbl.push_back(mk(1,1,0, 8'hA1, 1,0, 0,0, 0, 0,1, 0,0,0));
    tbl.push_back(mk(0,0,1, 8'h00, 0,0, 1,0, 1, 0,0, 0,0,1));
    tbl.push_back(mk(0,1,0, 8'h00, 0,1, 1,0, 1, 0,0, 0,0,0));
    tbl.push_back(mk(0,1,1, 8'h00, 0,0, 1,1, 0, 0,1, 1,0,0));
    tbl.push_back(mk(0,0,0, 8'h00, 0,0, 1,1, 0, 0,1, 0,0,1));

    do_reset();
    foreach (tbl[k]) apply(tbl[k], $sformatf("tbl%0d", k));

    // Wrap-around: fill, pop 3, push 3 into wrapped addresses, drain.
    do_reset();
    for (int i = 0; i < 8; i++)
      apply(mk(1,0,0, 8'(8'h21+i), 1,0, i,0, i, 0,(i==0), 0,0,0), "wfill");
    for (int i = 0; i < 3; i++)
      apply(mk(0,1,0, 8'h00, 0,1, 0,i, 8-i, (i==0),0, (i>0),0,0), "wpop3");
    for (int i = 0; i < 3; i++)
      apply(mk(1,0,0, 8'(8'h31+i), 1,0, i,3, 5+i, 0,0, (i==0),0,0), "wpush3");
    for (int i = 0; i < 8; i++)
      apply(mk(0,1,0, 8'h00, 0,1, 3,(3+i)%8, 8-i, (i==0),0, (i>0),0,0), "wdrain");

    // Refill, then push+pop at full: old word out, full holds.
    for (int i = 0; i < 8; i++)
      apply(mk(1,0,0, 8'(8'h50+i), 1,0, (3+i)%8,3, i, 0,(i==0), (i==0),0,0), "refill");
    apply(mk(1,1,0, 8'h66, 1,1, 3,3, 8, 1,0, 0,0,0), "fullpp");
    for (int i = 0; i < 3; i++)
      apply(mk(0,1,0, 8'h00, 0,1, 4,4+i, 8-i, (i==0),0, 1,0,0), "pop3");
    apply(mk(0,0,0, 8'h00, 0,0, 4,7, 5, 0,0, 1,0,0), "pre_rst");

    // Mid-stream reset with usedw=5.
    do_reset();
    apply(mk(0,0,0, 8'h00, 0,0, 0,0, 0, 0,1, 0,0,0), "post_rst");

    chk("sb_drained", 32'(rdq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time bound");
    $fatal(1);
  end

endmodule
